// File: rtl/x_uart_pkg.sv
// Shared UART definitions: frame-level state encoding and bit-timing helpers,
// used by both the word receiver and the word transmitter.
package x_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int half_bit(input int clk_hz, input int baud);
    return clks_per_bit(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/x_uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser plus frame FSM with registered strobes.
// o_idle exists only when X_UART_RX_TIMEOUT_EN is defined (feeds the inter-byte timer).
module x_uart_rx_byte
  import x_uart_pkg::*;
#(
  parameter int p_clk_hz = 16875000,
  parameter int p_baud   = 115200
) (
`ifdef X_UART_RX_TIMEOUT_EN
  output logic       o_idle,
`endif
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_byte,
  output logic       o_byte_vld,
  output logic       o_frame_err
);

  localparam int CPB   = clks_per_bit(p_clk_hz, p_baud);
  localparam int HALF  = half_bit(p_clk_hz, p_baud);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  uart_state_t      state_reg;
  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             rx_s;

  assign rx_s = sync_reg[1];

`ifdef X_UART_RX_TIMEOUT_EN
  assign o_idle = (state_reg == IDLE);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_reg    <= 2'b11;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      o_rx_byte   <= '0;
      o_byte_vld  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], i_uart_rx};
      o_byte_vld  <= 1'b0;
      o_frame_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg     <= '0;
          bit_idx_reg <= '0;
          if (!rx_s) state_reg <= START;
        end
        START: begin
          // mid-start-bit check rejects short glitches without flagging an error
          if (cnt_reg == CNT_W'(HALF - 1)) begin
            cnt_reg   <= '0;
            state_reg <= rx_s ? IDLE : DATA;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_reg == CNT_W'(CPB - 1)) begin
            cnt_reg     <= '0;
            shift_reg   <= {rx_s, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) state_reg <= STOP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_reg == CNT_W'(CPB - 1)) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
            if (rx_s) begin
              o_byte_vld <= 1'b1;
              o_rx_byte  <= shift_reg;
            end else begin
              o_frame_err <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/x_uart_rx_word.sv
// UART word receiver: packs p_length/8 received bytes (first byte in [7:0]) into o_data.
// Define X_UART_RX_TIMEOUT_EN to discard partial words after 16 idle bit times.
module x_uart_rx_word
  import x_uart_pkg::*;
#(
  parameter int p_length = 256,
  parameter int p_clk_hz = 16875000,
  parameter int p_baud   = 115200
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_uart_rx,
  output logic [p_length-1:0] o_data,
  output logic                o_valid,
  output logic                o_err
);

  localparam int NBYTES = p_length / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [7:0]          rx_byte;
  logic                byte_vld;
  logic                frame_err;
  logic                timeout_hit;
  logic [IDX_W-1:0]    byte_cnt_reg;
  logic [p_length-1:0] shadow_reg;
  logic [p_length-1:0] shadow_next;
  logic                last_byte;

`ifdef X_UART_RX_TIMEOUT_EN
  localparam int TO_CYCLES = 16 * clks_per_bit(p_clk_hz, p_baud);
  localparam int TO_W      = $clog2(TO_CYCLES + 1);

  logic            rx_idle;
  logic [TO_W-1:0] timer_reg;

  assign timeout_hit = rx_idle && (byte_cnt_reg != '0) && (timer_reg == TO_W'(TO_CYCLES - 1));

  // runs only while a partial word is pending; a start bit or the discard clears it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timer_reg <= '0;
    end else if (!rx_idle || byte_cnt_reg == '0) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_reg + TO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  x_uart_rx_byte #(
    .p_clk_hz (p_clk_hz),
    .p_baud   (p_baud)
  ) u_rx_byte (
`ifdef X_UART_RX_TIMEOUT_EN
    .o_idle      (rx_idle),
`endif
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_uart_rx   (i_uart_rx),
    .o_rx_byte   (rx_byte),
    .o_byte_vld  (byte_vld),
    .o_frame_err (frame_err)
  );

  // slot gi of the shadow takes the new byte when the counter points at it
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_slot
      assign shadow_next[8*gi +: 8] = (byte_vld && byte_cnt_reg == IDX_W'(gi))
                                      ? rx_byte : shadow_reg[8*gi +: 8];
    end
  endgenerate

  assign last_byte = (byte_cnt_reg == IDX_W'(NBYTES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_cnt_reg <= '0;
      shadow_reg   <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= frame_err | timeout_hit;
      if (byte_vld) begin
        shadow_reg <= shadow_next;
        if (last_byte) begin
          byte_cnt_reg <= '0;
          o_data       <= shadow_next;
          o_valid      <= 1'b1;
        end else begin
          byte_cnt_reg <= byte_cnt_reg + IDX_W'(1);
        end
      end
      if (timeout_hit) byte_cnt_reg <= '0;
    end
  end

endmodule

// File: tb/tb_x_uart_rx_word.sv
// Directed bench for x_uart_rx_word at p_length=32, 146 clocks per bit.
// Expectations for the idle-gap step follow X_UART_RX_TIMEOUT_EN when it is defined.
module tb_x_uart_rx_word;

  localparam int CPB = 146;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_err;

  int vectors     = 0;
  int miscompares = 0;
  int valid_cnt   = 0;
  int err_cnt     = 0;
  int both_cnt    = 0;
  logic [31:0] words [0:31];

  always #5 clk = ~clk;

  x_uart_rx_word #(
    .p_length (32),
    .p_clk_hz (16875000),
    .p_baud   (115200)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_uart_rx (rx),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_err     (o_err)
  );

  always @(negedge clk) begin
    if (o_valid && o_err) both_cnt++;
    if (o_valid) begin
      if (valid_cnt < 32) words[valid_cnt] = o_data;
      valid_cnt++;
    end
    if (o_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bits(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    bits(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bits(CPB);
    end
    if (stop_ok) begin
      rx = 1'b1;
      bits(CPB);
    end else begin
      rx = 1'b0;
      bits(100);
      rx = 1'b1;
      bits(CPB + 60);
    end
  endtask

  int v0, e0;

  initial begin
    // reset
    rst = 1'b1;
    rx  = 1'b1;
    bits(4);
    rst = 1'b0;
    bits(1);
    chk("reset_data", o_data, 32'h0);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_err", {31'd0, o_err}, 32'd0);

    // one word
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    bits(20);
    chk("w1_valid_count", 32'(valid_cnt - v0), 32'd1);
    chk("w1_data", o_data, 32'h44332211);
    chk("w1_err_count", 32'(err_cnt - e0), 32'd0);

    // two words back-to-back
    v0 = valid_cnt;
    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b1);
    bits(20);
    chk("b2b_valid_count", 32'(valid_cnt - v0), 32'd2);
    chk("b2b_word0", words[v0], 32'h03020100);
    chk("b2b_word1", words[v0 + 1], 32'h07060504);

    // framing error then a good word
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    bits(20);
    chk("ferr_err_count", 32'(err_cnt - e0), 32'd1);
    chk("ferr_valid_count", 32'(valid_cnt - v0), 32'd1);
    chk("ferr_data", o_data, 32'h44332211);

    // short low glitch
    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0; bits(30); rx = 1'b1; bits(400);
    chk("glitch_valid_count", 32'(valid_cnt - v0), 32'd0);
    chk("glitch_err_count", 32'(err_cnt - e0), 32'd0);

    // reset after a partial word
    send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
    rst = 1'b1; bits(1); rst = 1'b0; bits(1);
    chk("midreset_data", o_data, 32'h0);
    v0 = valid_cnt;
    send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
    bits(20);
    chk("midreset_valid_count", 32'(valid_cnt - v0), 32'd1);
    chk("midreset_word", o_data, 32'hEFBEADDE);

    // partial word, long idle, then four bytes
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    bits(2400);
    send_byte(8'h10, 1'b1); send_byte(8'h20, 1'b1);
    send_byte(8'h30, 1'b1); send_byte(8'h40, 1'b1);
    bits(20);
    chk("idle_valid_count", 32'(valid_cnt - v0), 32'd1);
`ifdef X_UART_RX_TIMEOUT_EN
    chk("idle_err_count", 32'(err_cnt - e0), 32'd1);
    chk("idle_word", o_data, 32'h40302010);
`else
    chk("idle_err_count", 32'(err_cnt - e0), 32'd0);
    chk("idle_word", o_data, 32'h20100201);
`endif

    chk("valid_err_overlap", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
